line_xfer_engine: RTL and testbench

LINE_XFER_ENGINE -- requirements
Module: line_xfer_engine

---
 rtl/line_xfer_engine.sv | 190 +++++++++++++++++++
 tb/tb_line_xfer_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_xfer_engine.sv
// Cache line transfer engine: optional 8-byte victim write-back, then an
// 8-byte line fill assembled into fill_data. Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_evict, evict_addr, evict_data, fill_addr
//   mem_addr, mem_wdata, mem_we (byte writes), mem_rdata (comb read data)
//   fill_valid (one-cycle pulse), fill_data (assembled line)
// Build option: define LINE_XFER_CWF_EN for critical-word-first fill order.
module line_xfer_engine #(
  parameter int LINE_BYTES = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_evict,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [63:0]       evict_data,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              fill_valid,
  output logic [63:0]       fill_data
);

  localparam int LAST = LINE_BYTES - 1;
  localparam logic [2:0] BEAT_LAST = LAST[2:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0] beat;
  logic       last_beat;
  logic       accept;

  // Latched request; the low address bits of the victim are don't-care.
  logic [ADDR_W-4:0] ev_line;
  logic [63:0]       ev_data;
  logic [ADDR_W-4:0] fl_line;
  logic              ev_flag;

  // Byte of the line read on the current FILL beat.
  logic [2:0] fill_byte;

  // Evict address offset has no meaning; the fill offset only matters
  // for critical-word-first ordering.
  logic unused_bits;

`ifdef LINE_XFER_CWF_EN
  logic [2:0] crit_off;
  assign unused_bits = ^evict_addr[2:0];
`else
  assign unused_bits = ^{evict_addr[2:0], fill_addr[2:0]};
`endif

  assign accept    = req_valid && req_ready;
  assign last_beat = (beat == BEAT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_evict ? WB : FILL;
        end
      end
      WB: begin
        if (last_beat) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Beat counter: restarts on accept and again between WB and FILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= 3'd0;
    end else if (accept) begin
      beat <= 3'd0;
    end else if (state == WB || state == FILL) begin
      beat <= last_beat ? 3'd0 : beat + 3'd1;
    end
  end

  // Request capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_line <= '0;
      ev_data <= '0;
      fl_line <= '0;
      ev_flag <= 1'b0;
    end else if (accept) begin
      ev_line <= evict_addr[ADDR_W-1:3];
      ev_data <= evict_data;
      fl_line <= fill_addr[ADDR_W-1:3];
      ev_flag <= req_evict;
    end
  end

`ifdef LINE_XFER_CWF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crit_off <= 3'd0;
    end else if (accept) begin
      crit_off <= fill_addr[2:0];
    end
  end

  // 3-bit add wraps byte 7 back to byte 0.
  assign fill_byte = crit_off + beat;
`else
  assign fill_byte = beat;
`endif

  // Fill assembly: each read byte lands at its own line position,
  // so the layout does not depend on the read order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_data <= '0;
    end else if (state == FILL) begin
      fill_data[{fill_byte, 3'b000} +: 8] <= mem_rdata;
    end
  end

  // Output logic; all memory signals are driven from state so that an
  // asynchronous reset silences the bus at once.
  always_comb begin
    req_ready  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    mem_we     = 1'b0;
    fill_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
      end
      WB: begin
        mem_addr  = {ev_line, beat};
        mem_wdata = ev_data[{beat, 3'b000} +: 8];
        mem_we    = 1'b1;
      end
      FILL: begin
        mem_addr = {fl_line, fill_byte};
      end
      DONE: begin
        fill_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // ev_flag is kept for the record of the accepted request; the
  // IDLE branch already chose WB or FILL from the live input.
  logic unused_flag;
  assign unused_flag = ev_flag ^ unused_bits;

endmodule

// File: tb/tb_line_xfer_engine.sv
// Directed bench for line_xfer_engine with a byte memory model whose
// unwritten locations read back as addr[7:0].
module tb_line_xfer_engine;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_evict;
  logic [31:0] evict_addr;
  logic [63:0] evict_data;
  logic [31:0] fill_addr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        fill_valid;
  logic [63:0] fill_data;

  int checks = 0;
  int errors = 0;

  line_xfer_engine #(.LINE_BYTES(8), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_evict  (req_evict),
    .evict_addr (evict_addr),
    .evict_data (evict_data),
    .fill_addr  (fill_addr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_data  (fill_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem     [0:4095];
  bit         written [0:4095];

  function automatic logic [7:0] mem_rd(input logic [11:0] a);
    return written[a] ? mem[a] : a[7:0];
  endfunction

  assign mem_rdata = mem_rd(mem_addr[11:0]);

  int wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[11:0]]     <= mem_wdata;
      written[mem_addr[11:0]] <= 1'b1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rd_byte(input logic [2:0] off,
                                         input logic [2:0] k);
`ifdef LINE_XFER_CWF_EN
    return off + k;
`else
    return k + 3'd0 * off;
`endif
  endfunction

  // Accept at cycle 0, beats on following cycles, then DONE pulse.
  task automatic run_req(input logic        ev,
                         input logic [31:0] ea,
                         input logic [63:0] ed,
                         input logic [31:0] fa,
                         input logic [63:0] exp);
    logic [2:0] b;
    @(negedge clk);
    req_valid  = 1'b1;
    req_evict  = ev;
    evict_addr = ea;
    evict_data = ed;
    fill_addr  = fa;
    check("accept_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (ev) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check("wb_we", mem_we, 1);
        check("wb_addr", mem_addr, {ea[31:3], k[2:0]});
        check("wb_data", mem_wdata, ed[8*k +: 8]);
        check("wb_ready", req_ready, 0);
        @(posedge clk);
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b = rd_byte(fa[2:0], k[2:0]);
      check("fill_addr", mem_addr, {fa[31:3], b});
      check("fill_we", mem_we, 0);
      check("fill_wdata", mem_wdata, 0);
      check("fill_fv", fill_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    check("done_fv", fill_valid, 1);
    check("done_data", fill_data, exp);
    check("done_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("idle_fv", fill_valid, 0);
    check("idle_ready", req_ready, 1);
    check("hold_data", fill_data, exp);
  endtask

  initial begin
    int fv_n;
    int acc_n;
    int acc_t[2];
    int fv_t[2];
    int wr0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_evict  = 1'b0;
    evict_addr = '0;
    evict_data = '0;
    fill_addr  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_fv", fill_valid, 0);
    check("rst_data", fill_data, 0);
    rst = 1'b0;

    // Plain fill of line 0x120.
    run_req(1'b0, 32'h0, 64'h0, 32'h0000_0123, 64'h2726_2524_2322_2120);

    // Write-back of 0x40 line, then fill of 0x80 line.
    run_req(1'b1, 32'h0000_0040, 64'h8877_6655_4433_2211,
            32'h0000_0080, 64'h8786_8584_8382_8180);
    check("mem_0x40", mem_rd(12'h040), 8'h11);
    check("mem_0x47", mem_rd(12'h047), 8'h88);

    // Critical offset 6: wraps in the CWF build, layout unchanged.
    run_req(1'b0, 32'h0, 64'h0, 32'h0000_0106, 64'h0706_0504_0302_0100);

    // Same-line victim and fill return the victim bytes.
    run_req(1'b1, 32'h0000_0200, 64'hdead_beef_0123_4567,
            32'h0000_0200, 64'hdead_beef_0123_4567);

    // Reset during write-back beat at cycle 4.
    @(negedge clk);
    req_valid  = 1'b1;
    req_evict  = 1'b1;
    evict_addr = 32'h0000_0300;
    evict_data = 64'hf7f6_f5f4_f3f2_f1f0;
    fill_addr  = 32'h0000_0380;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_we", mem_we, 1);
    wr0 = wr_cnt;
    rst = 1'b1;
    #1;
    check("abort_we", mem_we, 0);
    check("abort_addr", mem_addr, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fv_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fill_valid) fv_n++;
    end
    check("abort_fv", fv_n, 0);
    check("abort_wr", wr_cnt - wr0, 0);
    check("abort_ready", req_ready, 1);
    check("abort_b2", mem_rd(12'h302), 8'hf2);
    check("abort_b3", mem_rd(12'h303), 8'h03);

    // Request held high across two transfers.
    @(negedge clk);
    req_valid = 1'b1;
    req_evict = 1'b0;
    fill_addr = 32'h0000_0123;
    fv_n  = 0;
    acc_n = 0;
    for (int i = 0; i < 60; i++) begin
      if (fv_n == 2) begin
        req_valid = 1'b0;
        break;
      end
      if (req_valid && req_ready) begin
        if (acc_n < 2) acc_t[acc_n] = i;
        acc_n++;
      end
      if (fill_valid) begin
        fv_t[fv_n] = i;
        fv_n++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("held_fv_n", fv_n, 2);
    check("held_acc_n", acc_n, 2);
    if (fv_n == 2 && acc_n == 2) begin
      check("held_lat1", fv_t[0] - acc_t[0], 9);
      check("held_gap", acc_t[1] - fv_t[0], 1);
      check("held_lat2", fv_t[1] - acc_t[1], 9);
    end
    repeat (3) @(negedge clk);
    check("held_end_ready", req_ready, 1);
    check("held_end_data", fill_data, 64'h2726_2524_2322_2120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
